// File: rtl/stg4ma.sv
`default_nettype none
// ============================================================================
// Module   : stg4ma
// Brief    : MEM pipeline stage. ALU results pass through in one cycle; loads
//            and stores stall upstream until ack or a bounded wait timeout.
// Revision : 1.0
// ============================================================================
module stg4ma #(
    parameter int                  MEM_TIMEOUT = 15,
    parameter int                  SIZE_ADDR   = 16,
    parameter int                  SIZE_DATA   = 32,
    parameter int                  SIZE_OPC    = 5,
    parameter int                  SIZE_TGT_GP = 5,
    parameter int                  SIZE_TGT_SR = 3,
    parameter logic [SIZE_OPC-1:0] OPC_M_LD    = 'h10,
    parameter logic [SIZE_OPC-1:0] OPC_M_ST    = 'h11
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic                   iw_valid,
    input  logic [SIZE_ADDR-1:0]   iw_pc,
    input  logic [SIZE_OPC-1:0]    iw_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic [SIZE_DATA-1:0]   iw_result,
    input  logic [SIZE_DATA-1:0]   iw_st_data,
    output logic                   ow_stall,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [SIZE_ADDR-1:0]   ow_mem_addr,
    output logic [SIZE_DATA-1:0]   ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [SIZE_DATA-1:0]   iw_mem_rdata,
    output logic [SIZE_ADDR-1:0]   ow_pc,
    output logic [SIZE_OPC-1:0]    ow_opc,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic [SIZE_DATA-1:0]   ow_result,
    output logic                   ow_valid,
    output logic                   ow_mem_err
);

    localparam int         HBIT_ADDR  = SIZE_ADDR - 1;
    localparam logic [7:0] c_cnt_last = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic       w_is_mem;
    logic       w_accept_alu;
    logic       w_accept_mem;
    logic       w_ack_done;
    logic       w_timeout;

    assign w_is_mem = (iw_opc == OPC_M_LD) || (iw_opc == OPC_M_ST);
    assign ow_stall = (r_state == S_WAIT);

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ack is tested before the timeout so a late ack still completes cleanly.
    always_comb begin
        w_next_state = r_state;
        w_accept_alu = 1'b0;
        w_accept_mem = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iw_valid) begin
                    if (w_is_mem) begin
                        w_accept_mem = 1'b1;
                        w_next_state = S_WAIT;
                    end else begin
                        w_accept_alu = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (iw_mem_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_cnt        <= '0;
            ow_mem_req   <= 1'b0;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= '0;
            ow_mem_wdata <= '0;
            ow_pc        <= '0;
            ow_opc       <= '0;
            ow_tgt_gp    <= '0;
            ow_tgt_sr    <= '0;
            ow_result    <= '0;
            ow_valid     <= 1'b0;
            ow_mem_err   <= 1'b0;
        end else begin
            ow_mem_err <= w_timeout;
            if (w_accept_alu) begin
                ow_pc     <= iw_pc;
                ow_opc    <= iw_opc;
                ow_tgt_gp <= iw_tgt_gp;
                ow_tgt_sr <= iw_tgt_sr;
                ow_result <= iw_result;
                ow_valid  <= 1'b1;
            end else if (w_accept_mem) begin
                ow_pc        <= iw_pc;
                ow_opc       <= iw_opc;
                ow_tgt_gp    <= iw_tgt_gp;
                ow_tgt_sr    <= iw_tgt_sr;
                ow_valid     <= 1'b0;
                ow_mem_req   <= 1'b1;
                ow_mem_we    <= (iw_opc == OPC_M_ST);
                ow_mem_addr  <= iw_result[HBIT_ADDR:0];
                ow_mem_wdata <= (iw_opc == OPC_M_ST) ? iw_st_data : '0;
                r_cnt        <= '0;
            end else if (w_ack_done) begin
                ow_mem_req <= 1'b0;
                ow_valid   <= 1'b1;
                ow_result  <= ow_mem_we ? SIZE_DATA'(ow_mem_addr) : iw_mem_rdata;
            end else if (w_timeout) begin
                ow_mem_req <= 1'b0;
                ow_valid   <= 1'b1;
                ow_result  <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                ow_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stg4ma.sv
`default_nettype none
// ============================================================================
// Module   : tb_stg4ma
// Brief    : Randomized self-checking bench for stg4ma against a
//            transaction-level model (ack latency vs timeout -> outcome).
// Revision : 1.0
// ============================================================================
module tb_stg4ma;

    localparam int         T   = 4;
    localparam logic [4:0] LD  = 5'h10;
    localparam logic [4:0] ST  = 5'h11;
    localparam logic [4:0] ADD = 5'h01;

    logic        iw_clk = 1'b0;
    logic        iw_rst;
    logic        iw_valid;
    logic [15:0] iw_pc;
    logic [4:0]  iw_opc;
    logic [4:0]  iw_tgt_gp;
    logic [2:0]  iw_tgt_sr;
    logic [31:0] iw_result;
    logic [31:0] iw_st_data;
    logic        ow_stall;
    logic        ow_mem_req;
    logic        ow_mem_we;
    logic [15:0] ow_mem_addr;
    logic [31:0] ow_mem_wdata;
    logic        iw_mem_ack;
    logic [31:0] iw_mem_rdata;
    logic [15:0] ow_pc;
    logic [4:0]  ow_opc;
    logic [4:0]  ow_tgt_gp;
    logic [2:0]  ow_tgt_sr;
    logic [31:0] ow_result;
    logic        ow_valid;
    logic        ow_mem_err;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_res;

    stg4ma #(
        .MEM_TIMEOUT(T), .SIZE_ADDR(16), .SIZE_DATA(32), .SIZE_OPC(5),
        .SIZE_TGT_GP(5), .SIZE_TGT_SR(3), .OPC_M_LD(LD), .OPC_M_ST(ST)
    ) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_valid(iw_valid), .iw_pc(iw_pc),
        .iw_opc(iw_opc), .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr),
        .iw_result(iw_result), .iw_st_data(iw_st_data), .ow_stall(ow_stall),
        .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
        .ow_mem_wdata(ow_mem_wdata), .iw_mem_ack(iw_mem_ack),
        .iw_mem_rdata(iw_mem_rdata), .ow_pc(ow_pc), .ow_opc(ow_opc),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_sr(ow_tgt_sr), .ow_result(ow_result),
        .ow_valid(ow_valid), .ow_mem_err(ow_mem_err)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_zero"}, {ow_stall, ow_mem_req, ow_mem_we, ow_mem_addr, ow_valid,
                               ow_mem_err, ow_pc, ow_opc, ow_tgt_gp, ow_tgt_sr}, '0);
        check({tag, "_zres"}, {ow_mem_wdata, ow_result}, '0);
    endtask

    // One instruction; lat = cycle (1-based, within WAIT) on which ack arrives.
    task automatic run_op(input logic [4:0] opc, input logic [31:0] res,
                          input logic [31:0] sd, input logic [15:0] pc,
                          input int lat, input logic [31:0] rdata);
        logic        is_mem;
        logic [4:0]  gp;
        logic [2:0]  sr;
        logic [31:0] exp_res;
        logic        exp_err;
        int          waits;
        is_mem = (opc == LD) || (opc == ST);
        gp = 5'($urandom);
        sr = 3'($urandom);
        iw_valid = 1'b1; iw_opc = opc; iw_result = res; iw_st_data = sd;
        iw_pc = pc; iw_tgt_gp = gp; iw_tgt_sr = sr; iw_mem_ack = 1'($urandom);
        tick();
        check("pc", ow_pc, pc);
        check("opc", ow_opc, opc);
        check("tgt", {ow_tgt_gp, ow_tgt_sr}, {gp, sr});
        if (!is_mem) begin
            check("alu_valid", ow_valid, 1);
            check("alu_result", ow_result, res);
            check("alu_ctl", {ow_stall, ow_mem_req, ow_mem_err}, 3'b000);
            last_res = res;
            return;
        end
        check("req", {ow_mem_req, ow_mem_we, ow_valid, ow_stall}, {1'b1, opc == ST, 1'b0, 1'b1});
        check("addr", ow_mem_addr, res[15:0]);
        check("wdata", ow_mem_wdata, (opc == ST) ? sd : 32'h0);
        if (lat <= T) begin
            exp_err = 1'b0;
            exp_res = (opc == ST) ? {16'h0, res[15:0]} : rdata;
        end else begin
            exp_err = 1'b1;
            exp_res = 32'h0;
        end
        waits = (lat <= T) ? lat : T;
        for (int k = 1; k <= waits; k++) begin
            check("wait_ctl", {ow_stall, ow_mem_req, ow_valid, ow_mem_err}, 4'b1100);
            check("wait_addr", {ow_mem_addr, ow_mem_wdata},
                  {res[15:0], (opc == ST) ? sd : 32'h0});
            iw_valid = 1'($urandom); iw_opc = 5'($urandom); iw_result = $urandom;
            iw_pc = 16'($urandom); iw_st_data = $urandom;
            iw_mem_ack = (k == lat);
            iw_mem_rdata = (k == lat) ? rdata : $urandom;
            tick();
        end
        iw_mem_ack = 1'b0;
        iw_valid = 1'b0;
        check("done_valid", ow_valid, 1);
        check("done_result", ow_result, exp_res);
        check("done_err", ow_mem_err, exp_err);
        check("done_ctl", {ow_mem_req, ow_stall}, 2'b00);
        check("done_pc", {ow_pc, ow_opc}, {pc, opc});
        last_res = exp_res;
    endtask

    task automatic idle();
        iw_valid = 1'b0;
        iw_mem_ack = 1'($urandom);
        iw_mem_rdata = $urandom;
        tick();
        check("idle_ctl", {ow_valid, ow_stall, ow_mem_req, ow_mem_err}, 4'b0000);
        check("idle_hold", ow_result, last_res);
        iw_mem_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] opc;
        iw_rst = 1'b1; iw_valid = 1'b0; iw_pc = '0; iw_opc = '0; iw_tgt_gp = '0;
        iw_tgt_sr = '0; iw_result = '0; iw_st_data = '0; iw_mem_ack = 1'b0;
        iw_mem_rdata = '0; last_res = '0;
        tick(); tick();
        check_all_zero("reset");
        iw_rst = 1'b0;

        run_op(ADD, 32'h1234, 32'h0, 16'h0100, 0, 32'h0);
        run_op(LD, 32'h40, 32'h0, 16'h0104, 3, 32'hBEEF);
        run_op(ST, 32'h10, 32'hAA, 16'h0108, 1, 32'h5555);
        run_op(LD, 32'h80, 32'h0, 16'h010C, 99, 32'h1111);
        run_op(LD, 32'h84, 32'h0, 16'h0110, T, 32'hCAFE);
        run_op(ST, 32'hABCD_1234, 32'h77, 16'h0114, T + 1, 32'h0);
        idle();

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       opc = LD;
                1:       opc = ST;
                default: opc = 5'($urandom_range(0, 15));
            endcase
            run_op(opc, $urandom, $urandom, 16'($urandom), $urandom_range(1, T + 2), $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end

        run_op(LD, 32'h200, 32'h0, 16'h0300, 99, 32'h0);
        iw_valid = 1'b1; iw_opc = LD; iw_result = 32'h44; iw_pc = 16'h0400;
        tick();
        check("rst_wait_req", {ow_mem_req, ow_stall}, 2'b11);
        iw_valid = 1'b0;
        tick();
        iw_rst = 1'b1;
        tick();
        check_all_zero("rst_mid_wait");
        iw_rst = 1'b0; iw_mem_ack = 1'b1; iw_mem_rdata = 32'hDEAD;
        tick();
        iw_mem_ack = 1'b0;
        check_all_zero("ack_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
